// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator instruction issuer: opcode field,
// NOP word, FSM state encoding and the instruction word type.
package accel_pkg;

  localparam int OP_MSB = 63;
  localparam int OP_LSB = 60;

  localparam logic [3:0]  OP_READ_OUT = 4'hF;
  localparam logic [63:0] NOP         = 64'h0;

  typedef logic [63:0] instr_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RES = 1'b1
  } state_t;

  function automatic logic is_read_out(input instr_t instr);
    return instr[OP_MSB:OP_LSB] == OP_READ_OUT;
  endfunction

endpackage

// File: rtl/accel_instr_issuer_fifo.sv
// Synchronous, non-bypassing instruction FIFO with MSB-wrap pointers.
// Push is refused while full and pop is ignored while empty.
module issuer_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the head is only consumed while non-empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/accel_instr_issuer.sv
// Host-side issue engine: queues host instructions, issues them to the
// accelerator under back-pressure and captures READ_OUT results.
// Optional ACCEL_ISSUER_STATS_EN adds saturating issue/stall counters.
module accel_instr_issuer
  import accel_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RES_LAT    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  instr_t      i_host_instr,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  output instr_t      o_accelerator_input,
  input  logic        i_accelerator_full,
  input  logic [31:0] i_accelerator_output,
  output logic [31:0] o_result,
  output logic        o_result_valid,
  output logic        o_busy,
`ifdef ACCEL_ISSUER_STATS_EN
  output logic [15:0] o_instr_count,
  output logic [15:0] o_stall_count,
`endif
  output state_t      o_state
);

  localparam int CW = $clog2(RES_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RES_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  instr_t          r_acc_in;
  logic [31:0]     r_result;
  logic            r_result_valid;
  logic            w_full;
  logic            w_empty;
  instr_t          w_head;
  logic            w_issue;
  logic            w_capture;

  issuer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_host_valid),
    .i_data  (i_host_instr),
    .i_pop   (w_issue),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !i_accelerator_full) begin
          w_issue = 1'b1;
          if (is_read_out(w_head)) w_state_nxt = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_acc_in       <= NOP;
      r_result       <= 32'h0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc_in       <= w_issue ? w_head : NOP;
      r_result_valid <= w_capture;
      if (w_capture) r_result <= i_accelerator_output;
      if (w_issue && is_read_out(w_head)) r_cnt <= CNT_LOAD;
      else if (r_state == ST_WAIT_RES && r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
    end
  end

`ifdef ACCEL_ISSUER_STATS_EN
  logic [15:0] r_instr_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr_count <= 16'h0;
      r_stall_count <= 16'h0;
    end else begin
      if (w_issue && r_instr_count != 16'hFFFF)
        r_instr_count <= r_instr_count + 16'd1;
      if (r_state == ST_IDLE && !w_empty && i_accelerator_full && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_instr_count = r_instr_count;
  assign o_stall_count = r_stall_count;
`endif

  assign o_host_ready        = !w_full;
  assign o_accelerator_input = r_acc_in;
  assign o_result            = r_result;
  assign o_result_valid      = r_result_valid;
  assign o_busy              = !w_empty || (r_state == ST_WAIT_RES);
  assign o_state             = r_state;

endmodule

// File: tb/tb_accel_instr_issuer.sv
// Self-checking bench for accel_instr_issuer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_accel_instr_issuer;
  import accel_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] host_instr = 64'h0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [63:0] acc_in;
  logic        acc_full = 1'b0;
  logic [31:0] acc_out = 32'h0;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  state_t      state;
`ifdef ACCEL_ISSUER_STATS_EN
  logic [15:0] instr_count;
  logic [15:0] stall_count;
`endif

  accel_instr_issuer #(.FIFO_DEPTH(DEPTH), .RES_LAT(LAT)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_host_instr         (host_instr),
    .i_host_valid         (host_valid),
    .o_host_ready         (host_ready),
    .o_accelerator_input  (acc_in),
    .i_accelerator_full   (acc_full),
    .i_accelerator_output (acc_out),
    .o_result             (result),
    .o_result_valid       (result_valid),
    .o_busy               (busy),
`ifdef ACCEL_ISSUER_STATS_EN
    .o_instr_count        (instr_count),
    .o_stall_count        (stall_count),
`endif
    .o_state              (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: instruction queue plus the edge index of the last
  // READ_OUT issue; everything else follows from edge arithmetic.
  logic [63:0] mq[$];
  int          e = 0;
  int          rd_t = -1;
  int          t_drv = -1;
  logic [63:0] m_acc = 64'h0;
  logic [31:0] m_res = 32'h0;
  logic        m_rv = 1'b0;
  int          m_ic = 0;
  int          m_sc = 0;

  function automatic logic m_pending();
    return (rd_t >= 0) && (e <= rd_t + LAT);
  endfunction

  task automatic model_reset();
    mq.delete();
    rd_t = -1; t_drv = -1;
    m_acc = 64'h0; m_res = 32'h0; m_rv = 1'b0;
    m_ic = 0; m_sc = 0;
  endtask

  task automatic model_edge();
    int  sz;
    logic in_wait;
    e++;
    sz = mq.size();
    in_wait = (rd_t >= 0) && (e <= rd_t + LAT + 1);
    m_rv = (rd_t >= 0) && (e == rd_t + LAT + 1);
    if (m_rv) m_res = acc_out;
    if (!in_wait && sz > 0 && !acc_full) begin
      m_acc = mq.pop_front();
      if (m_acc[63:60] == 4'hF) rd_t = e;
      if (m_ic < 16'hFFFF) m_ic++;
    end else begin
      m_acc = 64'h0;
    end
    if (!in_wait && sz > 0 && acc_full && m_sc < 16'hFFFF) m_sc++;
    if (host_valid && sz < DEPTH) mq.push_back(host_instr);
  endtask

  task automatic check_all();
    chk("host_ready", 64'(host_ready), 64'(mq.size() < DEPTH));
    chk("acc_in", acc_in, m_acc);
    chk("result", 64'(result), 64'(m_res));
    chk("result_valid", 64'(result_valid), 64'(m_rv));
    chk("busy", 64'(busy), 64'(mq.size() > 0 || m_pending()));
    chk("state", 64'(state), 64'(m_pending() ? ST_WAIT_RES : ST_IDLE));
`ifdef ACCEL_ISSUER_STATS_EN
    chk("instr_count", 64'(instr_count), 64'(m_ic));
    chk("stall_count", 64'(stall_count), 64'(m_sc));
`endif
    if (acc_in[63:60] == 4'hF) t_drv = e;
    if (result_valid && t_drv >= 0) chk("rd_latency", 64'(e - t_drv), 64'(LAT + 1));
  endtask

  // Called at a negedge; checks, drives, advances one edge, ends at negedge.
  task automatic step(input logic v, input logic [63:0] d, input logic f, input logic [31:0] ao);
    check_all();
    host_valid = v; host_instr = d; acc_full = f; acc_out = ao;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    host_valid = 1'b0; host_instr = 64'h0; acc_full = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_host_ready", 64'(host_ready), 64'h1);
    chk("rst_acc_in", acc_in, 64'h0);
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_result_valid", 64'(result_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Three plain words issue back to back, then NOP.
    step(1'b1, 64'h1, 1'b0, 32'h0);
    step(1'b1, 64'h2, 1'b0, 32'h0);
    step(1'b1, 64'h3, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b0, 32'h0);

    // Back-pressure: nine pushes into a depth-8 queue, then drain.
    for (int i = 0; i < 9; i++) step(1'b1, 64'h100 + 64'(i), 1'b1, 32'h0);
    chk("bp_ready_low", 64'(host_ready), 64'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 64'h0, 1'b0, 32'h0);

    // READ_OUT followed by a queued word that must wait for the capture.
    step(1'b1, 64'hF000_0000_0000_0000, 1'b0, 32'hDEAD_BEEF);
    step(1'b1, 64'h5, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b0, 32'hDEAD_BEEF);
    chk("rd_result_const", 64'(result), 64'hDEAD_BEEF);

    // Reset during WAIT_RES aborts the read and drops queued work.
    step(1'b1, 64'hF000_0000_0000_0001, 1'b0, 32'h1234_5678);
    step(1'b1, 64'h7, 1'b0, 32'h1234_5678);
    step(1'b0, 64'h0, 1'b0, 32'h1234_5678);
    step(1'b0, 64'h0, 1'b0, 32'h1234_5678);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 64'h0, 1'b0, 32'h1234_5678);

    // Exactly full with simultaneous push and pop: push refused.
    for (int i = 0; i < 8; i++) step(1'b1, 64'h200 + 64'(i), 1'b1, 32'h0);
    step(1'b1, 64'h2FF, 1'b0, 32'h0);
    chk("full_pop_ready_up", 64'(host_ready), 64'h1);
    for (int i = 0; i < 12; i++) step(1'b0, 64'h0, 1'b0, 32'h0);

`ifdef ACCEL_ISSUER_STATS_EN
    do_reset();
    step(1'b1, 64'h11, 1'b1, 32'h0);
    step(1'b1, 64'h12, 1'b1, 32'h0);
    step(1'b0, 64'h0, 1'b1, 32'h0);
    step(1'b0, 64'h0, 1'b1, 32'h0);
    step(1'b0, 64'h0, 1'b0, 32'h0);
    step(1'b0, 64'h0, 1'b0, 32'h0);
    chk("stats_stall_const", 64'(stall_count), 64'd3);
    chk("stats_instr_const", 64'(instr_count), 64'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) d[63:60] = 4'hF;
      else if (d[63:60] == 4'hF) d[63:60] = 4'h1;
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 9) < 3), $urandom());
    end
    for (int i = 0; i < 40; i++) step(1'b0, 64'h0, 1'b0, $urandom());
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
